// File: rtl/reg_xfer_ctrl_pkg.sv
// Shared types and constants for the register-transfer sequencer.
package reg_xfer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WRITE = 2'd2
    } xfer_state_e;

    // Packed so that a_en lands on bit 0 and dst_en on bit 3.
    typedef struct packed {
        logic dst_en;
        logic c_en;
        logic b_en;
        logic a_en;
    } cmd_en_t;

    localparam int unsigned EN_A   = 0;
    localparam int unsigned EN_B   = 1;
    localparam int unsigned EN_C   = 2;
    localparam int unsigned EN_DST = 3;

    localparam int unsigned BUS_A     = 0;
    localparam int unsigned BUS_B     = 1;
    localparam int unsigned BUS_C     = 2;
    localparam int unsigned NUM_BUSES = 3;

endpackage

// File: rtl/cmd_fifo2.sv
// Two-entry synchronous command FIFO; push is ignored when full, pop when empty.
module cmd_fifo2 #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic [1:0]   count_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0] mem_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         do_push;
    logic         do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// Register-transfer sequencer: queues commands and drives register-file
// bus output enables and one-hot write enables through DRIVE/WRITE phases.
module reg_xfer_ctrl
    import reg_xfer_ctrl_pkg::*;
#(
    parameter int unsigned NREGS = 8,
    parameter int unsigned IDXW  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [IDXW-1:0]            cmd_src_a,
    input  logic [IDXW-1:0]            cmd_src_b,
    input  logic [IDXW-1:0]            cmd_src_c,
    input  logic [3:0]                 cmd_en,
    input  logic [IDXW-1:0]            cmd_dst,
    output logic [NUM_BUSES*NREGS-1:0] output_en,
    output logic [NREGS-1:0]           write_en,
    output logic                       busy,
    output logic                       done
);

    typedef struct packed {
        cmd_en_t         en;
        logic [IDXW-1:0] dst;
        logic [IDXW-1:0] src_c;
        logic [IDXW-1:0] src_b;
        logic [IDXW-1:0] src_a;
    } cmd_t;

    localparam int unsigned CMDW = $bits(cmd_t);

    cmd_t        cmd_in;
    cmd_t        fifo_head;
    logic [1:0]  fifo_count;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;

    xfer_state_e state_q, state_d;
    cmd_t        cmd_q, cmd_d;

    logic [NUM_BUSES*NREGS-1:0] oe_q, oe_d;
    logic [NREGS-1:0]           we_q, we_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    assign cmd_in = '{en: cmd_en_t'(cmd_en), dst: cmd_dst,
                      src_c: cmd_src_c, src_b: cmd_src_b, src_a: cmd_src_a};

    assign cmd_ready = (fifo_count < 2'd2);
    assign push      = cmd_valid && cmd_ready;

    cmd_fifo2 #(.W(CMDW)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .din_i   (cmd_in),
        .pop_i   (pop),
        .dout_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    full_matches_count: assert property (@(posedge clk) fifo_full == (fifo_count == 2'd2));

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    cmd_d   = fifo_head;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cmd_q.en.dst_en) begin
                    state_d = ST_WRITE;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    cmd_d   = fifo_head;
                    state_d = ST_DRIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    cmd_d   = fifo_head;
                    state_d = ST_DRIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the next state/command.
    always_comb begin
        oe_d   = '0;
        we_d   = '0;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_WRITE) ||
                 ((state_d == ST_DRIVE) && !cmd_d.en.dst_en);
        if (state_d != ST_IDLE) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (cmd_d.en.a_en && (cmd_d.src_a == IDXW'(i))) oe_d[NUM_BUSES*i + BUS_A] = 1'b1;
                if (cmd_d.en.b_en && (cmd_d.src_b == IDXW'(i))) oe_d[NUM_BUSES*i + BUS_B] = 1'b1;
                if (cmd_d.en.c_en && (cmd_d.src_c == IDXW'(i))) oe_d[NUM_BUSES*i + BUS_C] = 1'b1;
            end
        end
        if (state_d == ST_WRITE) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (cmd_d.dst == IDXW'(i)) we_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            oe_q    <= '0;
            we_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign output_en = oe_q;
    assign write_en  = we_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Directed bench for reg_xfer_ctrl: single-command vector table plus
// hand-written sequences for reset abort, back-to-back and read-after-write.
module tb_reg_xfer_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_src_a, cmd_src_b, cmd_src_c, cmd_dst;
    logic [3:0]  cmd_en;
    logic [23:0] output_en;
    logic [7:0]  write_en;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  sa;
        logic [2:0]  sb;
        logic [2:0]  sc;
        logic [3:0]  en;
        logic [2:0]  dst;
        logic [23:0] oe;
        logic [7:0]  we;
    } vec_t;

    vec_t vecs[7];

    reg_xfer_ctrl #(.NREGS(8), .IDXW(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_src_a (cmd_src_a),
        .cmd_src_b (cmd_src_b),
        .cmd_src_c (cmd_src_c),
        .cmd_en    (cmd_en),
        .cmd_dst   (cmd_dst),
        .output_en (output_en),
        .write_en  (write_en),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [23:0] oe, input logic [7:0] we,
                              input logic busy_e, input logic done_e);
        chk($sformatf("%s.output_en", tag), 32'(output_en), 32'(oe));
        chk($sformatf("%s.write_en", tag), 32'(write_en), 32'(we));
        chk($sformatf("%s.busy", tag), 32'(busy), 32'(busy_e));
        chk($sformatf("%s.done", tag), 32'(done), 32'(done_e));
    endtask

    task automatic set_cmd(input logic [2:0] sa, input logic [2:0] sb, input logic [2:0] sc,
                           input logic [3:0] en, input logic [2:0] dst);
        cmd_src_a = sa;
        cmd_src_b = sb;
        cmd_src_c = sc;
        cmd_en    = en;
        cmd_dst   = dst;
    endtask

    initial begin
        //           sa    sb    sc    en       dst   output_en   write_en
        vecs[0] = '{3'd2, 3'd3, 3'd0, 4'b1111, 3'd4, 24'h000444, 8'h10};
        vecs[1] = '{3'd1, 3'd1, 3'd1, 4'b0111, 3'd0, 24'h000038, 8'h00};
        vecs[2] = '{3'd5, 3'd6, 3'd7, 4'b0000, 3'd3, 24'h000000, 8'h00};
        vecs[3] = '{3'd7, 3'd0, 3'd0, 4'b1001, 3'd0, 24'h200000, 8'h01};
        vecs[4] = '{3'd0, 3'd0, 3'd7, 4'b0100, 3'd0, 24'h800000, 8'h00};
        vecs[5] = '{3'd0, 3'd5, 3'd0, 4'b1010, 3'd7, 24'h010000, 8'h80};
        vecs[6] = '{3'd0, 3'd0, 3'd0, 4'b0011, 3'd0, 24'h000003, 8'h00};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        set_cmd(3'd0, 3'd0, 3'd0, 4'b0000, 3'd0);
        tick();
        tick();
        expect_out("reset", 24'h0, 8'h0, 1'b0, 1'b0);
        chk("reset.cmd_ready", 32'(cmd_ready), 32'd1);
        reset = 1'b0;
        tick();

        // Reset in the WRITE cycle of a write to r5, with a second command queued.
        set_cmd(3'd0, 3'd0, 3'd0, 4'b1000, 3'd5);
        cmd_valid = 1'b1;
        tick();
        set_cmd(3'd4, 3'd0, 3'd0, 4'b0001, 3'd0);
        tick();
        expect_out("abort.drive", 24'h0, 8'h00, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        tick();
        expect_out("abort.write", 24'h0, 8'h20, 1'b1, 1'b1);
        reset = 1'b1;
        tick();
        expect_out("abort.reset", 24'h0, 8'h00, 1'b0, 1'b0);
        chk("abort.cmd_ready", 32'(cmd_ready), 32'd1);
        reset = 1'b0;
        tick();
        expect_out("abort.after1", 24'h0, 8'h00, 1'b0, 1'b0);
        tick();
        expect_out("abort.after2", 24'h0, 8'h00, 1'b0, 1'b0);

        // Single commands from an idle, empty block.
        for (int v = 0; v < 7; v++) begin
            set_cmd(vecs[v].sa, vecs[v].sb, vecs[v].sc, vecs[v].en, vecs[v].dst);
            cmd_valid = 1'b1;
            tick();
            cmd_valid = 1'b0;
            chk($sformatf("v%0d.queued_ready", v), 32'(cmd_ready), 32'd1);
            chk($sformatf("v%0d.queued_busy", v), 32'(busy), 32'd0);
            tick();
            expect_out($sformatf("v%0d.drive", v), vecs[v].oe, 8'h00, 1'b1, !vecs[v].en[3]);
            if (vecs[v].en[3]) begin
                tick();
                expect_out($sformatf("v%0d.write", v), vecs[v].oe, vecs[v].we, 1'b1, 1'b1);
            end
            tick();
            expect_out($sformatf("v%0d.idle", v), 24'h0, 8'h00, 1'b0, 1'b0);
        end

        // Three write commands pushed back-to-back.
        set_cmd(3'd1, 3'd0, 3'd0, 4'b1001, 3'd1);
        cmd_valid = 1'b1;
        tick();
        chk("b2b.ready0", 32'(cmd_ready), 32'd1);
        set_cmd(3'd2, 3'd0, 3'd0, 4'b1001, 3'd2);
        tick();
        expect_out("b2b.c1_drive", 24'h000008, 8'h00, 1'b1, 1'b0);
        chk("b2b.ready1", 32'(cmd_ready), 32'd1);
        set_cmd(3'd3, 3'd0, 3'd0, 4'b1001, 3'd3);
        tick();
        cmd_valid = 1'b0;
        expect_out("b2b.c1_write", 24'h000008, 8'h02, 1'b1, 1'b1);
        chk("b2b.ready_full", 32'(cmd_ready), 32'd0);
        tick();
        expect_out("b2b.c2_drive", 24'h000040, 8'h00, 1'b1, 1'b0);
        chk("b2b.ready_after_pop", 32'(cmd_ready), 32'd1);
        tick();
        expect_out("b2b.c2_write", 24'h000040, 8'h04, 1'b1, 1'b1);
        tick();
        expect_out("b2b.c3_drive", 24'h000200, 8'h00, 1'b1, 1'b0);
        tick();
        expect_out("b2b.c3_write", 24'h000200, 8'h08, 1'b1, 1'b1);
        tick();
        expect_out("b2b.idle", 24'h0, 8'h00, 1'b0, 1'b0);

        // Read-after-write: write r7, then read r7 on bus C with no stall.
        set_cmd(3'd0, 3'd0, 3'd0, 4'b1000, 3'd7);
        cmd_valid = 1'b1;
        tick();
        set_cmd(3'd0, 3'd0, 3'd7, 4'b0100, 3'd0);
        tick();
        cmd_valid = 1'b0;
        expect_out("raw.c1_drive", 24'h0, 8'h00, 1'b1, 1'b0);
        tick();
        expect_out("raw.c1_write", 24'h0, 8'h80, 1'b1, 1'b1);
        tick();
        expect_out("raw.c2_drive", 24'h800000, 8'h00, 1'b1, 1'b1);
        tick();
        expect_out("raw.idle", 24'h0, 8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
